obi_rr_mem_arbiter: RTL and testbench
=====================================

Name: obi_rr_mem_arbiter

Overview:
Shares one single-outstanding PULP memory port between NUM_MST OBI masters, e.g. CV32E40P instruction/data ports or several cores on one TCDM bank. Round-robin arbitration with OBI-stable request locking. At most one granted-but-unanswered transaction is in flight at any time. The response (rvalid/rdata) is routed back to the owning master. Sits between the core-side OBI ports and a memory that cannot accept a second request before answering the first.

Parameters:
NUM_MST, 2, number of requesting masters (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mst_req_i  in  NUM_MST  per-master request
mst_addr_i  in  NUM_MST*ADDR_WIDTH  per-master address
mst_we_i  in  NUM_MST  per-master write enable
mst_be_i  in  NUM_MST*DATA_WIDTH/8  per-master byte enables
mst_wdata_i  in  NUM_MST*DATA_WIDTH  per-master write data
mst_gnt_o  out  NUM_MST  per-master grant, one-hot or zero
mst_rvalid_o  out  NUM_MST  per-master response valid, one-hot or zero
mst_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters
mem_req_o  out  1  memory request
mem_addr_o  out  ADDR_WIDTH  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_gnt_i  in  1  memory grant
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_WIDTH  memory response data

Behaviour:
- Registered state:
  - FSM state {IDLE, WAIT_VALID}.
  - rr_ptr, log2(NUM_MST) bits: highest-priority index.
  - owner_q: index of the master with the outstanding transaction.
  - lock_q, lock_idx_q: a request is presented but not yet granted.
- Reset values: state=IDLE, rr_ptr=0, owner_q=0, lock_q=0, lock_idx_q=0.
- Reset also forces mst_gnt_o=0 and mst_rvalid_o=0. Reset mid-transaction drops ownership; any later mem_rvalid_i is ignored until a new grant.
- Arbitration (combinational):
  - Candidate index sel = lock_idx_q if lock_q, else the first asserted mst_req_i scanning rr_ptr, rr_ptr+1, ... modulo NUM_MST.
  - mem_* payload is muxed from sel.
- Issue window: open = (state==IDLE) || (state==WAIT_VALID && mem_rvalid_i).
  - This gives back-to-back issue in the response cycle, zero bubble.
- mem_req_o = open && |mst_req_i. Outside the window mem_req_o=0 and no mst_gnt_o is asserted.
- mst_gnt_o[sel] = mem_req_o && mem_gnt_i. All other bits are 0.
- Handshake with mem_req_o && mem_gnt_i (master k=sel):
  - next state WAIT_VALID; owner_q<=k; rr_ptr<=(k+1) mod NUM_MST; lock_q<=0.
- Request presented without grant:
  - lock_q<=1, lock_idx_q<=sel. Selection is held stable until granted, so mem_addr/we/be/wdata never change under a pending request.
  - Masters are OBI-compliant and do not drop req before gnt.
- WAIT_VALID:
  - mst_rvalid_o[owner_q] = mem_rvalid_i; mst_rdata_o = mem_rdata_i. Zero-latency pass-through.
  - mem_rvalid_i without a new handshake in the same cycle -> IDLE.
  - mem_rvalid_i with a new handshake in the same cycle -> stay WAIT_VALID with the new owner_q.
- IDLE: mem_rvalid_i is ignored; mst_rvalid_o=0. mst_rdata_o = mem_rdata_i, don't-care.
- mem_gnt_i while mem_req_o=0 is ignored.
- A master that has just been served gets lowest priority next arbitration; starvation-free.
- Latency: request-to-memory 0 cycles when idle; response-to-master 0 cycles.

Test Plan:
- Single master 0 read at addr 0x100, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> mst_gnt_o=01, then mst_rvalid_o=01 with rdata 0xDEADBEEF; mem_req_o=0 during wait even though master 0 reasserts req.
- Masters 0 and 1 request continuously, memory always grants and answers 1 cycle later -> grants alternate 0,1,0,1; each rvalid goes to the matching owner; back-to-back issue occurs in every rvalid cycle.
- Master 1 requests with addr 0x200 while mem_gnt_i is held 0 for 3 cycles; master 0 raises req in cycle 2 -> mem_addr_o stays 0x200; grant goes to master 1; master 0 is served next.
- rvalid and new gnt in the same cycle, owner changes 0->1 -> mst_rvalid_o=01 in that cycle; the next rvalid goes to master 1; state stays WAIT_VALID.
- Spurious mem_rvalid_i in IDLE, and mem_gnt_i with no req -> no mst_rvalid_o, no mst_gnt_o, state unchanged.
- rst_ni asserted while in WAIT_VALID, rr_ptr=1 -> state=IDLE, rr_ptr=0; the post-reset rvalid is not forwarded; master 0 wins the first contended arbitration.

Source files
------------

// File: rtl/obi_rr_mem_arbiter.sv
// Round-robin OBI arbiter in front of a single-outstanding memory port.
// Pending requests are locked until granted; responses route back to the owner.
module obi_rr_arb_port #(
  parameter int IDX_W = 1,
  parameter int IDX   = 0
) (
  input  logic             i_hs,
  input  logic             i_rsp,
  input  logic [IDX_W-1:0] i_sel,
  input  logic [IDX_W-1:0] i_owner,
  output logic             o_gnt,
  output logic             o_rvalid
);
  assign o_gnt    = i_hs  && (i_sel   == IDX_W'(IDX));
  assign o_rvalid = i_rsp && (i_owner == IDX_W'(IDX));
endmodule

module obi_rr_mem_arbiter #(
  parameter int NUM_MST    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_MST-1:0]               mst_req_i,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]    mst_addr_i,
  input  logic [NUM_MST-1:0]               mst_we_i,
  input  logic [NUM_MST*DATA_WIDTH/8-1:0]  mst_be_i,
  input  logic [NUM_MST*DATA_WIDTH-1:0]    mst_wdata_i,
  output logic [NUM_MST-1:0]               mst_gnt_o,
  output logic [NUM_MST-1:0]               mst_rvalid_o,
  output logic [DATA_WIDTH-1:0]            mst_rdata_o,
  output logic                             mem_req_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic                             mem_we_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  input  logic                             mem_gnt_i,
  input  logic                             mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i
);
  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_MST);

  typedef enum logic {IDLE, WAIT_VALID} state_e;

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic               r_lock, w_lock_nxt;
  logic [IDX_W-1:0]   r_lock_idx, w_lock_idx_nxt;

  logic [IDX_W-1:0]   w_sel;
  logic               w_found;
  logic               w_open;
  logic               w_hs;
  logic               w_rsp;

  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NUM_L) s = s - NUM_L;
    return s[IDX_W-1:0];
  endfunction

  // A locked selection overrides the scan so the payload cannot change under a pending req.
  always_comb begin
    w_sel   = r_rr_ptr;
    w_found = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (!w_found && mst_req_i[mod_add(r_rr_ptr, IDX_W'(i))]) begin
        w_found = 1'b1;
        w_sel   = mod_add(r_rr_ptr, IDX_W'(i));
      end
    end
    if (r_lock) w_sel = r_lock_idx;
  end

  // Response cycle reopens the window, giving back-to-back issue.
  assign w_open    = rst_ni && ((r_state == IDLE) || mem_rvalid_i);
  assign mem_req_o = w_open && (|mst_req_i);
  assign w_hs      = mem_req_o && mem_gnt_i;
  assign w_rsp     = (r_state == WAIT_VALID) && mem_rvalid_i;

  assign mem_addr_o  = mst_addr_i [w_sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_we_o    = mst_we_i   [w_sel];
  assign mem_be_o    = mst_be_i   [w_sel*BE_W +: BE_W];
  assign mem_wdata_o = mst_wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign mst_rdata_o = mem_rdata_i;

  for (genvar g = 0; g < NUM_MST; g++) begin : g_port
    obi_rr_arb_port #(.IDX_W(IDX_W), .IDX(g)) u_port (
      .i_hs     (w_hs),
      .i_rsp    (w_rsp),
      .i_sel    (w_sel),
      .i_owner  (r_owner),
      .o_gnt    (mst_gnt_o[g]),
      .o_rvalid (mst_rvalid_o[g])
    );
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_nxt       = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_lock_nxt     = r_lock;
    w_lock_idx_nxt = r_lock_idx;
    if (w_hs) begin
      w_state_nxt = WAIT_VALID;
      w_owner_nxt = w_sel;
      w_rr_nxt    = mod_add(w_sel, IDX_W'(1));
      w_lock_nxt  = 1'b0;
    end else begin
      if (mem_req_o) begin
        w_lock_nxt     = 1'b1;
        w_lock_idx_nxt = w_sel;
      end
      if (w_rsp) w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock     <= w_lock_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end
endmodule

// File: tb/tb_obi_rr_mem_arbiter.sv
// Directed bench for obi_rr_mem_arbiter with two masters; inputs driven on negedge.
module tb_obi_rr_mem_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NM-1:0]     mst_req_i;
  logic [NM*AW-1:0]  mst_addr_i;
  logic [NM-1:0]     mst_we_i;
  logic [NM*DW/8-1:0] mst_be_i;
  logic [NM*DW-1:0]  mst_wdata_i;
  logic [NM-1:0]     mst_gnt_o;
  logic [NM-1:0]     mst_rvalid_o;
  logic [DW-1:0]     mst_rdata_o;
  logic              mem_req_o;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_we_o;
  logic [DW/8-1:0]   mem_be_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DW-1:0]     mem_rdata_i;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  obi_rr_mem_arbiter #(.NUM_MST(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mst_req_i(mst_req_i), .mst_addr_i(mst_addr_i), .mst_we_i(mst_we_i),
    .mst_be_i(mst_be_i), .mst_wdata_i(mst_wdata_i),
    .mst_gnt_o(mst_gnt_o), .mst_rvalid_o(mst_rvalid_o), .mst_rdata_o(mst_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs at negedge, then let combinational outputs settle.
  task automatic cyc(input logic [1:0] req, input logic gnt, input logic rv,
                     input logic [31:0] rd);
    @(negedge clk_i);
    mst_req_i    = req;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #1;
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    mst_addr_i[m*AW +: AW]  = a;
    mst_we_i[m]             = we;
    mst_be_i[m*4 +: 4]      = be;
    mst_wdata_i[m*DW +: DW] = wd;
  endtask

  initial begin
    rst_ni = 1'b0;
    mst_req_i = '0; mst_addr_i = '0; mst_we_i = '0; mst_be_i = '0; mst_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // reset state: request and grant visible, yet nothing passes
    cyc(2'b11, 1'b1, 1'b1, 32'h0);
    chk("rst_gnt", mst_gnt_o, 2'b00);
    chk("rst_rvalid", mst_rvalid_o, 2'b00);
    chk("rst_memreq", mem_req_o, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    rst_ni = 1'b1;

    // single master read
    set_m(0, 32'h100, 1'b0, 4'hF, 32'h0);
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("t1_req", mem_req_o, 1'b1);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_gnt", mst_gnt_o, 2'b01);
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("t1_wait_req", mem_req_o, 1'b0);
    chk("t1_wait_gnt", mst_gnt_o, 2'b00);
    cyc(2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
    chk("t1_rvalid", mst_rvalid_o, 2'b01);
    chk("t1_rdata", mst_rdata_o, 32'hDEADBEEF);

    // spurious rvalid and gnt while idle
    cyc(2'b00, 1'b1, 1'b1, 32'h55);
    chk("t5_rvalid", mst_rvalid_o, 2'b00);
    chk("t5_gnt", mst_gnt_o, 2'b00);
    chk("t5_req", mem_req_o, 1'b0);
    // still idle with rr_ptr=1: master 1 issues at once, with its write payload
    set_m(1, 32'h300, 1'b1, 4'h3, 32'h12345678);
    cyc(2'b10, 1'b1, 1'b0, 32'h0);
    chk("t5_gnt1", mst_gnt_o, 2'b10);
    chk("t5_we", mem_we_o, 1'b1);
    chk("t5_be", mem_be_o, 4'h3);
    chk("t5_wdata", mem_wdata_o, 32'h12345678);
    cyc(2'b00, 1'b0, 1'b1, 32'hA5);
    chk("t5_rvalid1", mst_rvalid_o, 2'b10);

    // both masters continuous, memory answers next cycle: alternating grants
    set_m(1, 32'h200, 1'b0, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 1'b1, (i != 0), 32'h1000 + 32'(i));
      chk("t2_gnt", mst_gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t2_rvalid", mst_rvalid_o, (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10));
      chk("t2_req", mem_req_o, 1'b1);
    end
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    chk("t2_last_rvalid", mst_rvalid_o, 2'b10);

    // stalled grant: master 1 locked, master 0 arrives with higher rr priority
    set_m(0, 32'h400, 1'b0, 4'hF, 32'h0);
    cyc(2'b10, 1'b0, 1'b0, 32'h0);
    chk("t3_addr_c1", mem_addr_o, 32'h200);
    chk("t3_gnt_c1", mst_gnt_o, 2'b00);
    cyc(2'b11, 1'b0, 1'b0, 32'h0);
    chk("t3_addr_c2", mem_addr_o, 32'h200);
    cyc(2'b11, 1'b0, 1'b0, 32'h0);
    chk("t3_addr_c3", mem_addr_o, 32'h200);
    cyc(2'b11, 1'b1, 1'b0, 32'h0);
    chk("t3_gnt", mst_gnt_o, 2'b10);
    chk("t3_addr_gnt", mem_addr_o, 32'h200);
    // rvalid for master 1 and back-to-back grant to master 0
    cyc(2'b01, 1'b1, 1'b1, 32'hBEEF);
    chk("t4_rvalid", mst_rvalid_o, 2'b10);
    chk("t4_gnt", mst_gnt_o, 2'b01);
    chk("t4_addr", mem_addr_o, 32'h400);
    cyc(2'b00, 1'b0, 1'b1, 32'hCAFE);
    chk("t4_rvalid_next", mst_rvalid_o, 2'b01);
    chk("t4_rdata", mst_rdata_o, 32'hCAFE);

    // reset during WAIT_VALID with rr_ptr=1
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    chk("t6_gnt", mst_gnt_o, 2'b01);
    @(negedge clk_i);
    rst_ni = 1'b0; mst_req_i = 2'b00; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    chk("t6_rst_rvalid", mst_rvalid_o, 2'b00);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("t6_post_rvalid", mst_rvalid_o, 2'b00);
    cyc(2'b11, 1'b1, 1'b0, 32'h0);
    chk("t6_first_gnt", mst_gnt_o, 2'b01);
    chk("t6_first_addr", mem_addr_o, 32'h400);
    cyc(2'b00, 1'b0, 1'b1, 32'h77);
    chk("t6_rvalid", mst_rvalid_o, 2'b01);

    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
